sbox_arbiter: RTL and testbench

SBOX_ARBITER -- requirements
Module: sbox_arbiter

---
 rtl/bcrypt_pkg.sv | 20 ++
 rtl/sbox_rd_capture.sv | 29 ++
 rtl/sbox_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sbox_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcrypt_pkg.sv
// Shared S-box geometry and arbiter state encoding for the bcrypt core.
package bcrypt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRE    = 2'd1,
    ACCESS = 2'd2
  } arb_state_t;

  localparam int STARVE_LIMIT = 4;
  localparam int SBOX_BANKS   = 4;
  localparam int SBOX_ROW_W   = 7;
  localparam int SBOX_WORD_W  = 32;

  // Each rd_addr byte selects a row with bits [7:1]; bit 0 picks the half.
  function automatic logic [SBOX_ROW_W-1:0] row_of(input logic [7:0] addr_byte);
    return addr_byte[7:1];
  endfunction

endpackage

// File: rtl/sbox_rd_capture.sv
// One bank's read-out register: selects the 32-bit half of the row and holds it
// until the next read access completes.
module sbox_rd_capture
  import bcrypt_pkg::*;
#(
  parameter int DATA_W = SBOX_WORD_W
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  load,
  input  logic                  sel_hi,
  input  logic [2*DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]     s
);

  logic [DATA_W-1:0] half_p0;

  assign half_p0 = sel_hi ? rdata[2*DATA_W-1:DATA_W] : rdata[DATA_W-1:0];

  // p0 -> p1: register the selected half at the end of the read access
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s <= '0;
    end else if (load) begin
      s <= half_p0;
    end
  end

endmodule

// File: rtl/sbox_arbiter.sv
// Arbitrates S-box bank access between F-function reads and key-schedule writes:
// precharge/access sequencing, read priority, bounded write starvation.
module sbox_arbiter
  import bcrypt_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   rd_req,
  input  logic [31:0]            rd_addr,
  output logic                   rd_ack,
  output logic                   rd_valid,
  output logic [SBOX_WORD_W-1:0] s0,
  output logic [SBOX_WORD_W-1:0] s1,
  output logic [SBOX_WORD_W-1:0] s2,
  output logic [SBOX_WORD_W-1:0] s3,
  input  logic                   wr_req,
  input  logic [1:0]             wr_bank,
  input  logic [SBOX_ROW_W-1:0]  wr_addr,
  input  logic [63:0]            wr_data,
  output logic                   wr_ack,
  output logic                   precharge,
  output logic [SBOX_BANKS-1:0]  wl_en,
  output logic [SBOX_ROW_W-1:0]  wl_0,
  output logic [SBOX_ROW_W-1:0]  wl_1,
  output logic [SBOX_ROW_W-1:0]  wl_2,
  output logic [SBOX_ROW_W-1:0]  wl_3,
  output logic [SBOX_BANKS-1:0]  we,
  output logic [63:0]            bl_wdata,
  input  logic [63:0]            bank_rdata_0,
  input  logic [63:0]            bank_rdata_1,
  input  logic [63:0]            bank_rdata_2,
  input  logic [63:0]            bank_rdata_3,
  output logic                   busy
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  arb_state_t            state, state_nxt;
  logic [2:0]            starve_cnt, starve_nxt;
  logic                  arm_q, grant_ok, gnt_rd, gnt_wr;
  logic                  op_rd_q, op_wr_q;
  logic [31:0]           rd_addr_p0;
  logic [1:0]            wr_bank_p0;
  logic [SBOX_ROW_W-1:0] wr_addr_p0;
  logic [63:0]           wr_data_p0;
  logic                  vld_p1, cap_load;
  logic [SBOX_ROW_W-1:0] wl_a    [SBOX_BANKS];
  logic [63:0]           rdata_a [SBOX_BANKS];
  logic [SBOX_WORD_W-1:0] s_a    [SBOX_BANKS];

  // Grants happen only on edges that enter PRE; arm_q holds off the first edge after reset.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    grant_ok   = 1'b0;
    gnt_rd     = 1'b0;
    gnt_wr     = 1'b0;
    case (state)
      IDLE:    grant_ok = arm_q;
      PRE:     state_nxt = ACCESS;
      ACCESS: begin
        grant_ok  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (grant_ok && (rd_req || wr_req)) begin
      state_nxt = PRE;
      if (wr_req && (!rd_req || starve_cnt >= STARVE_MAX)) gnt_wr = 1'b1;
      else                                                gnt_rd = 1'b1;
    end
    if (gnt_wr) begin
      starve_nxt = '0;
    end else if (gnt_rd && wr_req && starve_cnt < STARVE_MAX) begin
      starve_nxt = starve_cnt + 3'd1;
    end
  end

  // control registers: state, starvation, granted operation, read-valid pulse
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      starve_cnt <= '0;
      arm_q      <= 1'b0;
      op_rd_q    <= 1'b0;
      op_wr_q    <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      arm_q      <= 1'b1;
      vld_p1     <= cap_load;
      if (gnt_rd || gnt_wr) begin
        op_rd_q <= gnt_rd;
        op_wr_q <= gnt_wr;
      end
    end
  end

  // p0: address/data captured at the grant edge
  always_ff @(posedge clk) begin
    if (gnt_rd) rd_addr_p0 <= rd_addr;
    if (gnt_wr) begin
      wr_bank_p0 <= wr_bank;
      wr_addr_p0 <= wr_addr;
      wr_data_p0 <= wr_data;
    end
  end

  always_comb begin
    wl_en    = '0;
    we       = '0;
    bl_wdata = '0;
    for (int n = 0; n < SBOX_BANKS; n++) wl_a[n] = '0;
    if (state == ACCESS) begin
      if (op_rd_q) begin
        wl_en = '1;
        for (int n = 0; n < SBOX_BANKS; n++) wl_a[n] = row_of(rd_addr_p0[8*n +: 8]);
      end else if (op_wr_q) begin
        wl_en[wr_bank_p0] = 1'b1;
        we[wr_bank_p0]    = 1'b1;
        wl_a[wr_bank_p0]  = wr_addr_p0;
        bl_wdata          = wr_data_p0;
      end
    end
  end

  assign cap_load  = (state == ACCESS) && op_rd_q;
  assign precharge = (state == PRE);
  assign rd_ack    = (state == PRE) && op_rd_q;
  assign wr_ack    = (state == PRE) && op_wr_q;
  assign busy      = (state != IDLE);
  assign rd_valid  = vld_p1;

  assign wl_0 = wl_a[0];
  assign wl_1 = wl_a[1];
  assign wl_2 = wl_a[2];
  assign wl_3 = wl_a[3];

  assign rdata_a[0] = bank_rdata_0;
  assign rdata_a[1] = bank_rdata_1;
  assign rdata_a[2] = bank_rdata_2;
  assign rdata_a[3] = bank_rdata_3;

  for (genvar n = 0; n < SBOX_BANKS; n++) begin : g_cap
    sbox_rd_capture u_cap (
      .clk    (clk),
      .rst_l  (rst_l),
      .load   (cap_load),
      .sel_hi (rd_addr_p0[8*n]),
      .rdata  (rdata_a[n]),
      .s      (s_a[n])
    );
  end

  assign s0 = s_a[0];
  assign s1 = s_a[1];
  assign s2 = s_a[2];
  assign s3 = s_a[3];

endmodule

// File: tb/tb_sbox_arbiter.sv
// Bench for sbox_arbiter: transaction-level reference model with per-cycle
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_sbox_arbiter;

  logic        clk = 1'b0;
  logic        rst_l, rd_req, rd_ack, rd_valid, wr_req, wr_ack, precharge, busy;
  logic [31:0] rd_addr, s0, s1, s2, s3;
  logic [1:0]  wr_bank;
  logic [6:0]  wr_addr, wl_0, wl_1, wl_2, wl_3;
  logic [63:0] wr_data, bl_wdata, bank_rdata_0, bank_rdata_1, bank_rdata_2, bank_rdata_3;
  logic [3:0]  wl_en, we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sbox_arbiter dut (
    .clk(clk), .rst_l(rst_l),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .wr_req(wr_req), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .precharge(precharge), .wl_en(wl_en),
    .wl_0(wl_0), .wl_1(wl_1), .wl_2(wl_2), .wl_3(wl_3),
    .we(we), .bl_wdata(bl_wdata),
    .bank_rdata_0(bank_rdata_0), .bank_rdata_1(bank_rdata_1),
    .bank_rdata_2(bank_rdata_2), .bank_rdata_3(bank_rdata_3),
    .busy(busy)
  );

  function automatic logic [63:0] pat(input int n, input int r);
    logic [7:0] bn, br;
    bn = n[7:0];
    br = r[7:0];
    return {bn, br, 16'hA5A5, ~bn, br, 16'h5A5A};
  endfunction

  // Bank storage seen by the DUT, written through its own wordline/we outputs.
  logic [63:0] dut_mem [4][128];
  bit          dut_mem_ready;
  logic [6:0]  wl_v [4];
  assign wl_v[0] = wl_0;
  assign wl_v[1] = wl_1;
  assign wl_v[2] = wl_2;
  assign wl_v[3] = wl_3;
  assign bank_rdata_0 = dut_mem[0][wl_0];
  assign bank_rdata_1 = dut_mem[1][wl_1];
  assign bank_rdata_2 = dut_mem[2][wl_2];
  assign bank_rdata_3 = dut_mem[3][wl_3];

  always @(posedge clk) begin
    if (!dut_mem_ready) begin
      for (int n = 0; n < 4; n++)
        for (int r = 0; r < 128; r++) dut_mem[n][r] <= pat(n, r);
      dut_mem_ready <= 1'b1;
    end else begin
      for (int n = 0; n < 4; n++)
        if (we[n] === 1'b1) dut_mem[n][wl_v[n]] <= bl_wdata;
    end
  end

  // Reference model: one transaction in flight, age 1 = precharge cycle, age 2 = access cycle.
  logic [63:0] ref_mem [4][128];
  bit          ref_ready;
  int          m_age, m_starve;
  bit          m_is_rd, m_armed, m_valid;
  logic [31:0] m_raddr;
  logic [1:0]  m_wbank;
  logic [6:0]  m_wrow;
  logic [63:0] m_wdata;
  logic [31:0] m_s [4];

  always @(posedge clk or negedge rst_l) begin : model
    bit take_wr;
    logic [63:0] w;
    if (!ref_ready) begin
      for (int n = 0; n < 4; n++)
        for (int r = 0; r < 128; r++) ref_mem[n][r] = pat(n, r);
      ref_ready = 1'b1;
    end
    if (!rst_l) begin
      m_age = 0; m_starve = 0; m_is_rd = 0; m_armed = 0; m_valid = 0;
      for (int n = 0; n < 4; n++) m_s[n] = '0;
    end else begin
      m_valid = (m_age == 2) && m_is_rd;
      if (m_valid)
        for (int n = 0; n < 4; n++) begin
          w = ref_mem[n][m_raddr[8*n+1 +: 7]];
          m_s[n] = m_raddr[8*n] ? w[63:32] : w[31:0];
        end
      if (m_age == 2 && !m_is_rd) ref_mem[m_wbank][m_wrow] = m_wdata;
      if (((m_age == 0 && m_armed) || m_age == 2) && (rd_req || wr_req)) begin
        take_wr = wr_req && (!rd_req || m_starve >= 4);
        if (take_wr) begin
          m_starve = 0; m_is_rd = 0;
          m_wbank = wr_bank; m_wrow = wr_addr; m_wdata = wr_data;
        end else begin
          if (wr_req && m_starve < 4) m_starve = m_starve + 1;
          m_is_rd = 1; m_raddr = rd_addr;
        end
        m_age = 1;
      end else begin
        m_age = (m_age == 1) ? 2 : 0;
      end
      m_armed = 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [3:0]  e_wlen, e_we;
    logic [6:0]  e_wl [4];
    logic [63:0] e_bl;
    e_wlen = '0; e_we = '0; e_bl = '0;
    for (int n = 0; n < 4; n++) e_wl[n] = '0;
    if (m_age == 2) begin
      if (m_is_rd) begin
        e_wlen = 4'hF;
        for (int n = 0; n < 4; n++) e_wl[n] = m_raddr[8*n+1 +: 7];
      end else begin
        e_wlen[m_wbank] = 1'b1;
        e_we[m_wbank]   = 1'b1;
        e_wl[m_wbank]   = m_wrow;
        e_bl            = m_wdata;
      end
    end
    chk("rd_ack",    64'(rd_ack),    64'(m_age == 1 && m_is_rd));
    chk("wr_ack",    64'(wr_ack),    64'(m_age == 1 && !m_is_rd));
    chk("precharge", 64'(precharge), 64'(m_age == 1));
    chk("busy",      64'(busy),      64'(m_age != 0));
    chk("rd_valid",  64'(rd_valid),  64'(m_valid));
    chk("wl_en",     64'(wl_en),     64'(e_wlen));
    chk("we",        64'(we),        64'(e_we));
    chk("bl_wdata",  bl_wdata,       e_bl);
    chk("wl_0",      64'(wl_0),      64'(e_wl[0]));
    chk("wl_1",      64'(wl_1),      64'(e_wl[1]));
    chk("wl_2",      64'(wl_2),      64'(e_wl[2]));
    chk("wl_3",      64'(wl_3),      64'(e_wl[3]));
    chk("s0",        64'(s0),        64'(m_s[0]));
    chk("s1",        64'(s1),        64'(m_s[1]));
    chk("s2",        64'(s2),        64'(m_s[2]));
    chk("s3",        64'(s3),        64'(m_s[3]));
  endtask

  bit chk_en;
  always begin
    @(posedge clk);
    #2;
    if (chk_en) compare_all();
  end

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic wait_ack(input bit for_wr);
    for (int i = 0; i < 20; i++) begin
      sample();
      if ((for_wr ? wr_ack : rd_ack) === 1'b1) return;
    end
    chk("ack_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ng, nv, acks, last, bad_gap, busy_low, n_we, n_rd;
    int g [10];
    int exp_g [10];
    exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    rst_l = 1'b0; rd_req = 0; rd_addr = '0; wr_req = 0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    sample();
    chk_en = 1'b1;

    // Single read; the edge right after reset release must not grant.
    do_reset();
    rd_addr = 32'h0301FE81; rd_req = 1'b1;
    sample();
    chk("rd_no_early_grant", 64'(rd_ack), 64'd0);
    sample();
    chk("rd_ack_k1", 64'(rd_ack), 64'd1);
    chk("rd_pre", 64'(precharge), 64'd1);
    #3 rd_req = 1'b0;
    sample();
    chk("rd_acc_wlen", 64'(wl_en), 64'hF);
    chk("rd_acc_wl0", 64'(wl_0), 64'h40);
    chk("rd_acc_wl1", 64'(wl_1), 64'h7F);
    chk("rd_acc_wl2", 64'(wl_2), 64'h00);
    chk("rd_acc_wl3", 64'(wl_3), 64'h01);
    chk("rd_acc_novalid", 64'(rd_valid), 64'd0);
    sample();
    chk("rd_valid_k3", 64'(rd_valid), 64'd1);
    chk("rd_s0_hi", 64'(s0), 64'h0040A5A5);
    chk("rd_s1_lo", 64'(s1), 64'hFE7F5A5A);
    chk("rd_s2_hi", 64'(s2), 64'h0200A5A5);
    // byte3 = 0x03: row 1, bit 0 set, so the high half
    chk("rd_s3_hi", 64'(s3), 64'h0301A5A5);
    sample();
    chk("rd_valid_pulse", 64'(rd_valid), 64'd0);

    // Single write to bank 2.
    @(negedge clk);
    wr_bank = 2'd2; wr_addr = 7'h15; wr_data = 64'hDEADBEEF_01234567; wr_req = 1'b1;
    wait_ack(1'b1);
    #3 wr_req = 1'b0;
    n_we = 0;
    repeat (4) begin
      sample();
      if (we !== 4'h0) begin
        n_we++;
        chk("wr_we", 64'(we), 64'h4);
        chk("wr_wlen", 64'(wl_en), 64'h4);
        chk("wr_wl2", 64'(wl_2), 64'h15);
        chk("wr_wl_other", 64'({wl_0, wl_1, wl_3}), 64'd0);
        chk("wr_bl", bl_wdata, 64'hDEADBEEF_01234567);
      end
    end
    chk("wr_cycles", 64'(n_we), 64'd1);
    chk("wr_s0_held", 64'(s0), 64'h0040A5A5);

    // Starvation: both held high from reset.
    @(negedge clk);
    rst_l = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = $urandom; wr_bank = 2'd1; wr_addr = 7'h33; wr_data = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    sample();
    chk("st_no_early_grant", 64'({rd_ack, wr_ack}), 64'd0);
    ng = 0; cyc = 0;
    while (ng < 10 && cyc < 60) begin
      sample();
      cyc++;
      if (rd_ack === 1'b1) begin g[ng] = 0; ng++; end
      else if (wr_ack === 1'b1) begin g[ng] = 1; ng++; end
    end
    chk("st_grants", 64'(ng), 64'd10);
    for (int i = 0; i < 10; i++) chk("st_pattern", 64'(g[i]), 64'(exp_g[i]));
    #3 rd_req = 1'b0; wr_req = 1'b0;
    repeat (4) sample();

    // Ten back-to-back reads.
    @(negedge clk);
    rd_req = 1'b1; rd_addr = $urandom;
    acks = 0; nv = 0; last = -1; bad_gap = 0; busy_low = 0; cyc = 0;
    while (nv < 10 && cyc < 80) begin
      sample();
      cyc++;
      if (rd_ack === 1'b1) acks++;
      if (acks > 0 && busy !== 1'b1 && !(rd_valid === 1'b1 && nv == 9)) busy_low++;
      if (rd_valid === 1'b1) begin
        if (last >= 0 && cyc - last != 2) bad_gap++;
        last = cyc;
        nv++;
      end
      if (rd_ack === 1'b1) begin
        #3 rd_addr = $urandom;
        if (acks == 10) rd_req = 1'b0;
      end
    end
    chk("b2b_valids", 64'(nv), 64'd10);
    chk("b2b_acks", 64'(acks), 64'd10);
    chk("b2b_gap", 64'(bad_gap), 64'd0);
    chk("b2b_busy", 64'(busy_low), 64'd0);
    repeat (2) sample();

    // Reset during the access cycle of a read.
    @(negedge clk);
    rd_addr = $urandom; rd_req = 1'b1;
    wait_ack(1'b0);
    #3 rd_req = 1'b0;
    sample();
    chk("ra_in_access", 64'(wl_en), 64'hF);
    #1 rst_l = 1'b0;
    #1;
    chk("ra_s", 64'({s0, s1}), 64'd0);
    chk("ra_s_hi", 64'({s2, s3}), 64'd0);
    chk("ra_busy", 64'(busy), 64'd0);
    chk("ra_ctl", 64'({rd_valid, precharge, wl_en, we}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    nv = 0;
    repeat (4) begin
      sample();
      if (rd_valid === 1'b1) nv++;
    end
    chk("ra_no_valid", 64'(nv), 64'd0);
    @(negedge clk);
    rd_addr = 32'h0; rd_req = 1'b1;
    wait_ack(1'b0);
    #3 rd_req = 1'b0;
    sample();
    sample();
    chk("ra_next_valid", 64'(rd_valid), 64'd1);
    chk("ra_next_s0", 64'(s0), 64'hFF005A5A);
    chk("ra_next_s3", 64'(s3), 64'hFC005A5A);

    // Read request withdrawn before any grant while a write waits.
    @(negedge clk);
    rst_l = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = $urandom; wr_bank = 2'd3; wr_addr = 7'h2A; wr_data = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    sample();
    chk("dr_no_grant", 64'({rd_ack, wr_ack}), 64'd0);
    #3 rd_req = 1'b0;
    sample();
    chk("dr_wr_ack", 64'(wr_ack), 64'd1);
    chk("dr_rd_ack", 64'(rd_ack), 64'd0);
    #3 wr_req = 1'b0;
    n_rd = 0; n_we = 0;
    repeat (4) begin
      sample();
      if (wl_en !== 4'h0 && we === 4'h0) n_rd++;
      if (we !== 4'h0) n_we++;
    end
    chk("dr_no_read", 64'(n_rd), 64'd0);
    chk("dr_one_write", 64'(n_we), 64'd1);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rd_req  = ($urandom_range(0, 3) != 0);
      rd_addr = $urandom;
      wr_req  = ($urandom_range(0, 1) == 1);
      wr_bank = 2'($urandom_range(0, 3));
      wr_addr = 7'($urandom_range(0, 127));
      wr_data = {$urandom, $urandom};
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk);
        #3 rst_l = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_l = 1'b1;
      end
    end
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (4) sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
